// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for pipe_stage_reg: the upstream (in_*) and downstream (out_*) sides.
// master = the environment driving the stage, slave = the stage itself.
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Single-entry valid/ready pipeline register with flush and a saturating back-pressure counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry and drive in_ready from state only.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  pipe_stage_reg_if.slave       bus,
  output logic [15:0]           stall_cnt
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q,  main_data_d;
  logic [15:0]      stall_cnt_q,  stall_cnt_d;
  logic             accept;
  logic             drain;

  assign accept = bus.in_valid && bus.in_ready;
  assign drain  = main_valid_q && bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;

  // Only registered state feeds in_ready, so out_ready never reaches the upstream stage.
  assign bus.in_ready = !skid_valid_q && !flush && !reset;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_data_d  = bus.in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_data_d  = bus.in_data;
        skid_valid_d = 1'b1;
      end else begin
        main_data_d  = bus.in_data;
        main_valid_d = 1'b1;
      end
    end
  end

  // NOTE: skid_data_q is qualified by skid_valid_q, so only the valid bit needs a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
    end
    skid_data_q <= skid_data_d;
  end
`else
  assign bus.in_ready = (!main_valid_q || bus.out_ready) && !flush && !reset;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_data_d  = bus.in_data;
    end else if (drain) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !bus.out_ready && !flush && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous and overrides flush and handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= RESET_VAL;
      stall_cnt_q  <= 16'd0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.out_valid = main_valid_q;
  assign bus.out_data  = main_data_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data path width in bits (legal 1..128).
REQ-002 Parameter RESET_VAL, default 0, SHALL set the value loaded into out_data on reset (WIDTH bits).
REQ-003 clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 flush  input  1  SHALL request discard of all held entries (synchronous, active-high).
REQ-006 in_valid  input  1  SHALL mark in_data as valid from the upstream stage.
REQ-007 in_ready  output  1  SHALL indicate the stage accepts in_data this cycle.
REQ-008 in_data  input  WIDTH  SHALL carry the upstream payload (PC, instruction word, etc.).
REQ-009 out_valid  output  1  SHALL mark out_data as valid to the downstream stage.
REQ-010 out_ready  input  1  SHALL indicate downstream accepts out_data this cycle.
REQ-011 out_data  output  WIDTH  SHALL carry the registered payload.
REQ-012 stall_cnt  output  16  SHALL report downstream back-pressure cycles.

Function
REQ-013 A transfer SHALL occur on an edge where in_valid=1 and in_ready=1, or where out_valid=1 and out_ready=1; no other condition moves data.
REQ-014 Latency from an accepted input to out_valid=1 with that data SHALL be exactly 1 cycle.
REQ-015 Data SHALL leave in acceptance order; no entry SHALL be lost or duplicated.
REQ-016 Base mode (macro absent): a single main entry; in_ready SHALL be (!out_valid || out_ready) && !flush, combinationally.
REQ-017 Base mode: on accept, out_data SHALL take in_data and out_valid SHALL be 1 on the next cycle, including when the old entry drains on the same edge.
REQ-018 When the entry drains with no input accepted, out_valid SHALL go to 0 and out_data SHALL hold its last value.
REQ-019 While out_valid=1 and out_ready=0, out_data and out_valid SHALL remain stable.
REQ-020 flush=1 SHALL force in_ready=0 in the same cycle and clear out_valid (and any skid entry) on the next edge; out_data SHALL hold.
REQ-021 flush SHALL take priority over any simultaneous accept or drain; a drain that handshakes in the flush cycle SHALL count as delivered downstream.
REQ-022 stall_cnt SHALL increment by 1 on each edge where out_valid=1, out_ready=0 and flush=0, and SHALL saturate at 16'hFFFF.
REQ-023 stall_cnt SHALL NOT be cleared by flush.

Reset
REQ-024 reset=1 SHALL on the next edge set out_valid=0, out_data=RESET_VAL, stall_cnt=0, and clear any skid entry.
REQ-025 reset SHALL take priority over flush and all handshakes.
REQ-026 While reset=1, in_ready SHALL be 0.
REQ-027 Reset asserted while out_valid=1 and out_ready=0 SHALL discard the held entry with no downstream transfer.

Configuration
REQ-028 Macro PIPE_STAGE_SKID_EN, when defined, SHALL add a second (skid) entry of WIDTH bits.
REQ-029 With PIPE_STAGE_SKID_EN, in_ready SHALL be driven from a register as !skid_valid && !flush, with no combinational path from out_ready.
REQ-030 With PIPE_STAGE_SKID_EN, an input accepted while the main entry is held (out_ready=0) SHALL go to the skid entry.
REQ-031 With PIPE_STAGE_SKID_EN, on a drain with skid_valid=1, the skid entry SHALL move to main next cycle and in_ready SHALL return to 1.
REQ-032 With PIPE_STAGE_SKID_EN, sustained throughput SHALL be 1 transfer per cycle when out_ready=1.
REQ-033 Without PIPE_STAGE_SKID_EN, the behaviour SHALL be exactly REQ-016..REQ-019 and no skid storage SHALL be built.

Verification
REQ-034 Reset pulse with RESET_VAL=32'h40 -> out_valid=0, out_data=32'h40, stall_cnt=0, in_ready=0 during reset.
REQ-035 Stream 21,22,23 with out_ready=1 -> out_data 21,22,23 on consecutive cycles one cycle after each input; stall_cnt=0.
REQ-036 Hold 21 with out_ready=0 for 5 cycles -> out_data stable at 21, stall_cnt=5; base mode in_ready=0, skid mode accepts 22 then in_ready=0; release -> 21 then 22 delivered in order.
REQ-037 Flush with in_valid=1, data 99, while holding 21 -> in_ready=0 that cycle, out_valid=0 next cycle, 99 never appears, stall_cnt unchanged.
REQ-038 Reset and flush both asserted with a held entry -> reset values result (REQ-024); stall_cnt=0.
REQ-039 Preload stall_cnt to 16'hFFFE via back-pressure, then stall 3 more cycles -> stall_cnt=16'hFFFF with no wrap.
